// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/issue bundle between the ALU, LSU, decode stage and the register-file arbiter.
// The slave modport is the arbiter; the master modport is the requester side.
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_val;

  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_val;

  logic        w_enable;
  logic [4:0]  w_reg_name;
  logic [31:0] w_reg_val;

  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic        iss_stall;
  logic [31:0] sb_busy;

  modport slave (
    input  alu_valid, alu_rd, alu_val,
    input  lsu_valid, lsu_rd, lsu_val,
    input  iss_valid, iss_rd, iss_rs1, iss_rs2,
    output alu_ready, lsu_ready,
    output w_enable, w_reg_name, w_reg_val,
    output iss_stall, sb_busy
  );

  modport master (
    output alu_valid, alu_rd, alu_val,
    output lsu_valid, lsu_rd, lsu_val,
    output iss_valid, iss_rd, iss_rs1, iss_rs2,
    input  alu_ready, lsu_ready,
    input  w_enable, w_reg_name, w_reg_val,
    input  iss_stall, sb_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter (ALU/LSU) with a registered register-file write port
// and a busy-bit scoreboard that stalls issue on RAW/WAW hazards.
//
// state     | meaning
// LAST_ALU  | ALU won the most recent transfer; LSU wins the next contention
// LAST_LSU  | LSU won the most recent transfer (reset state); ALU wins the next contention
module regfile_wb_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_LSU = 1'b1
  } grant_state_t;

  grant_state_t state_q;
  grant_state_t state_d;

  logic        alu_grant;
  logic        lsu_grant;
  logic        xfer;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;

  logic        w_enable_q;
  logic [4:0]  w_reg_name_q;
  logic [31:0] w_reg_val_q;

  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic        stall;
  logic        issue_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LAST_LSU;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants depend only on the valids and the grant history, never on a ready.
  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    state_d   = state_q;
    if (!rst) begin
      if (bus.alu_valid && bus.lsu_valid) begin
        if (RR_ENABLE) begin
          if (state_q == LAST_LSU) begin
            alu_grant = 1'b1;
          end else begin
            lsu_grant = 1'b1;
          end
        end else begin
          lsu_grant = 1'b1;
        end
      end else if (bus.alu_valid) begin
        alu_grant = 1'b1;
      end else if (bus.lsu_valid) begin
        lsu_grant = 1'b1;
      end

      if (alu_grant) begin
        state_d = LAST_ALU;
      end else if (lsu_grant) begin
        state_d = LAST_LSU;
      end
    end
  end

  assign xfer   = alu_grant | lsu_grant;
  assign wb_rd  = lsu_grant ? bus.lsu_rd  : bus.alu_rd;
  assign wb_val = lsu_grant ? bus.lsu_val : bus.alu_val;

  // Name/value follow every transfer, including rd=0, but only rd!=0 enables the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_enable_q   <= 1'b0;
      w_reg_name_q <= 5'd0;
      w_reg_val_q  <= 32'd0;
    end else if (xfer) begin
      w_enable_q   <= (wb_rd != 5'd0);
      w_reg_name_q <= wb_rd;
      w_reg_val_q  <= wb_val;
    end else begin
      w_enable_q   <= 1'b0;
    end
  end

  assign stall = !rst && bus.iss_valid &&
                 (busy_q[bus.iss_rs1] || busy_q[bus.iss_rs2] || busy_q[bus.iss_rd]);
  assign issue_fire = bus.iss_valid && !stall;

  always_comb begin
    clr_mask = 32'd0;
    set_mask = 32'd0;
    if (w_enable_q) begin
      clr_mask[w_reg_name_q] = 1'b1;
    end
    if (issue_fire && (bus.iss_rd != 5'd0)) begin
      set_mask[bus.iss_rd] = 1'b1;
    end
    // Set is applied after clear so it wins on a collision; x0 is never busy.
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.alu_ready  = alu_grant;
  assign bus.lsu_ready  = lsu_grant;
  assign bus.w_enable   = w_enable_q;
  assign bus.w_reg_name = w_reg_name_q;
  assign bus.w_reg_val  = w_reg_val_q;
  assign bus.iss_stall  = stall;
  assign bus.sb_busy    = busy_q;

endmodule
